addsub_seq: RTL and testbench



---
 rtl/addsub_seq_pkg.sv | 23 ++
 rtl/addsub_seq_chunk.sv | 47 ++++
 rtl/addsub_seq.sv | 134 +++++++++++++
 tb/tb_addsub_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared ALU definitions for the sequential adder/subtractor.
//   state_t        : controller states (IDLE, RUN, DONE)
//   OP_ADD/OP_SUB  : encodings of the 'op' input
//   FLAG_*         : bit positions if the four flags are bundled as
//                    {cout, ovf, zero, neg} into a 4-bit vector
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FLAG_NEG  = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_COUT = 3;
    localparam int FLAG_W    = 4;

endpackage

// File: rtl/addsub_seq_chunk.sv
// CHUNK-bit ripple-carry adder slice built from single-bit full adders.
// Ports:
//   a, b  : CHUNK-bit slice operands
//   cin   : carry into bit 0
//   sum   : CHUNK-bit slice sum
//   cout  : carry out of the top bit
//   cmsb  : carry into the top bit (used for signed-overflow detection)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            full_adder u_fa (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .sum  (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout = carry[CHUNK];
    assign cmsb = carry[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor computing CHUNK bits per clock with
// the carry registered between slices.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, accepted only when not busy
//   op                  : 0 = a+b+cin, 1 = a-b-cin (cin is borrow-in)
//   cin, a, b           : operands, captured on acceptance
//   busy                : high while slices are being computed
//   done                : one-cycle pulse, result and flags valid
//   result              : sum/difference, held until the next accepted op
//   cout, ovf, zero, neg: carry-out (sub: 1 = no borrow), signed overflow,
//                         result==0, result MSB
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    import addsub_seq_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;        // already inverted for subtraction
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             neg_reg;

    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;
    logic [CHUNK-1:0] sum_cur;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             is_last;

    // Slice mux: select the operand bits for the current slice index.
    assign a_cur   = a_reg[idx_reg*CHUNK +: CHUNK];
    assign b_cur   = b_reg[idx_reg*CHUNK +: CHUNK];
    assign is_last = (idx_reg == LAST_IDX);

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_cur),
        .b    (b_cur),
        .cin  (carry_reg),
        .sum  (sum_cur),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // Slice demux: the current slice is replaced, every other slice keeps its
    // old value. The full vector is also what the zero flag looks at.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign result_next[gi*CHUNK +: CHUNK] =
                (idx_reg == IDX_W'(gi)) ? sum_cur : result_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            idx_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow: invert once here so
                        // the slice datapath is a plain adder.
                        a_reg     <= a;
                        b_reg     <= (op == OP_SUB) ? ~b : b;
                        carry_reg <= (op == OP_SUB) ? ~cin : cin;
                        idx_reg   <= '0;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= slice_cout;
                    if (is_last) begin
                        cout_reg  <= slice_cout;
                        ovf_reg   <= slice_cmsb ^ slice_cout;
                        zero_reg  <= (result_next == '0);
                        neg_reg   <= result_next[WIDTH-1];
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign cout   = cout_reg;
    assign ovf    = ovf_reg;
    assign zero   = zero_reg;
    assign neg    = neg_reg;

endmodule

// File: tb/tb_addsub_seq.sv
module tb_addsub_seq;

    logic clk;
    logic rst;

    // 16-bit, 4-bit slices
    logic        start16, op16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16, zero16, neg16;
    logic [15:0] res16;

    // 8-bit, shared stimulus for the CHUNK=8 and CHUNK=1 builds
    logic        start8, op8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8w, done8w, cout8w, ovf8w, zero8w, neg8w;
    logic [7:0]  res8w;
    logic        busy8n, done8n, cout8n, ovf8n, zero8n, neg8n;
    logic [7:0]  res8n;

    int checks   = 0;
    int failures = 0;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .cin(cin16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .result(res16),
        .cout(cout16), .ovf(ovf16), .zero(zero16), .neg(neg16)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8w (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8w), .done(done8w), .result(res8w),
        .cout(cout8w), .ovf(ovf8w), .zero(zero8w), .neg(neg8w)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(1)) dut8n (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8n), .done(done8n), .result(res8n),
        .cout(cout8n), .ovf(ovf8n), .zero(zero8n), .neg(neg8n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one 16-bit op (from IDLE or DONE), wait for done, check latency,
    // busy duration, result and {cout,ovf,zero,neg}. Returns in the done cycle.
    task automatic run16(input string tag, input logic o, input logic c,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic [3:0] ef);
        int lat;
        int bc;
        op16 = o; cin16 = c; a16 = av; b16 = bv; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        lat = 0;
        bc  = 0;
        while (!done16 && lat < 20) begin
            if (busy16) bc++;
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, 4);
        check({tag, ".busy_cycles"}, bc, 4);
        check({tag, ".result"}, {16'h0, res16}, {16'h0, er});
        check({tag, ".flags"}, {28'h0, cout16, ovf16, zero16, neg16}, {28'h0, ef});
        $display("op16 %s op=%0d a=%h b=%h cin=%0d -> result=%h flags=%b latency=%0d",
                 tag, o, av, bv, c, res16, {cout16, ovf16, zero16, neg16}, lat);
    endtask

    // Run one op on both 8-bit builds; each must finish with the same result
    // at its own latency.
    task automatic run8(input string tag, input logic o, input logic c,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic [3:0] ef);
        int cnt;
        int lat_w;
        int lat_n;
        logic [11:0] out_w;
        logic [11:0] out_n;
        op8 = o; cin8 = c; a8 = av; b8 = bv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cnt = 0; lat_w = -1; lat_n = -1;
        out_w = '0; out_n = '0;
        while ((lat_w < 0 || lat_n < 0) && cnt < 20) begin
            if (done8w && lat_w < 0) begin
                lat_w = cnt;
                out_w = {res8w, cout8w, ovf8w, zero8w, neg8w};
            end
            if (done8n && lat_n < 0) begin
                lat_n = cnt;
                out_n = {res8n, cout8n, ovf8n, zero8n, neg8n};
            end
            tick();
            cnt++;
        end
        check({tag, ".c8_latency"}, lat_w, 1);
        check({tag, ".c8_out"}, {20'h0, out_w}, {20'h0, er, ef});
        check({tag, ".c1_latency"}, lat_n, 8);
        check({tag, ".c1_out"}, {20'h0, out_n}, {20'h0, er, ef});
        $display("op8 %s a=%h b=%h -> chunk8 out=%h lat=%0d, chunk1 out=%h lat=%0d",
                 tag, av, bv, out_w, lat_w, out_n, lat_n);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        start16 = 1'b0; op16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
        start8  = 1'b0; op8  = 1'b0; cin8  = 1'b0; a8  = '0; b8  = '0;
        tick();
        tick();

        // Reset state
        check("reset.busy_done", {30'h0, busy16, done16}, 32'h0);
        check("reset.result", {16'h0, res16}, 32'h0);
        check("reset.flags", {28'h0, cout16, ovf16, zero16, neg16}, 32'h0);
        check("reset.w8", {busy8w, done8w, res8w, cout8w, ovf8w, zero8w, neg8w,
                           busy8n, done8n, res8n, cout8n, ovf8n, zero8n, neg8n}, 32'h0);
        $display("reset applied");
        rst = 1'b0;
        tick();

        // flags are {cout, ovf, zero, neg}
        run16("add_ff_1",    1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000);
        tick();
        check("add_ff_1.done_pulse", {31'h0, done16}, 32'h0);
        check("add_ff_1.held", {16'h0, res16}, 32'h0100);
        run16("add_7fff_1",  1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        tick();
        run16("add_ffff_c",  1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010);
        tick();
        run16("sub_0_1",     1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b0001);
        tick();
        run16("sub_8000_1",  1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100);
        tick();

        // start pulsed mid-RUN with different operands must be ignored
        op16 = 1'b0; cin16 = 1'b0; a16 = 16'h1234; b16 = 16'h1111; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        op16 = 1'b1; cin16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        lat = 2;
        while (!done16 && lat < 20) begin
            tick();
            lat++;
        end
        check("midrun.latency", lat, 4);
        check("midrun.result", {16'h0, res16}, 32'h2345);
        check("midrun.flags", {28'h0, cout16, ovf16, zero16, neg16}, 32'h0);
        $display("midrun ignored start: result=%h latency=%0d", res16, lat);
        tick();
        check("midrun.no_queue", {30'h0, busy16, done16}, 32'h0);

        // Back-to-back: second start presented in the DONE cycle
        run16("b2b_first",   1'b0, 1'b0, 16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000);
        run16("b2b_second",  1'b1, 1'b1, 16'h1000, 16'h0001, 16'h0FFE, 4'b1000);
        tick();

        // Reset during slice 2 discards the op and clears outputs
        op16 = 1'b0; cin16 = 1'b0; a16 = 16'hAAAA; b16 = 16'h5555; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid.busy_done", {30'h0, busy16, done16}, 32'h0);
        check("rst_mid.result", {16'h0, res16}, 32'h0);
        check("rst_mid.flags", {28'h0, cout16, ovf16, zero16, neg16}, 32'h0);
        $display("reset mid-op: result=%h busy=%0d", res16, busy16);
        rst = 1'b0;
        tick();
        run16("after_rst",   1'b0, 1'b0, 16'h0F0F, 16'hF0F0, 16'hFFFF, 4'b0001);
        tick();

        // 8-bit builds: single-cycle and bit-serial
        run8("add_80_80", 1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 4'b1110);
        tick();
        run8("sub_5_3_b", 1'b1, 1'b1, 8'h05, 8'h03, 8'h01, 4'b1000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
